// File: rtl/rr_mux_reg.sv
// rr_mux_reg: N-input arbitrating multiplexer with a single registered output stage.
// Each input channel and the output use a valid/ready handshake. RR_MODE selects
// round-robin (1) or fixed lowest-index priority (0) arbitration.
//
// Ports:
//   CLK        rising-edge clock
//   RST        synchronous, active-high reset
//   IN_VALID   per-channel data-present flags
//   IN_DATA    channel i data at [i*WIDTH +: WIDTH]
//   IN_READY   per-channel accept (combinational, at most one bit high)
//   OUT_VALID  output register holds valid data
//   OUT_DATA   registered data of the granted channel
//   OUT_SEL    index of the channel whose data is in OUT_DATA
//   OUT_READY  consumer accepts OUT_DATA this cycle
module rr_mux_reg #(
    parameter int WIDTH   = 32,
    parameter int N_IN    = 4,
    parameter int RR_MODE = 1,
    parameter int SEL_W   = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [N_IN-1:0]         IN_VALID,
    input  logic [N_IN*WIDTH-1:0]   IN_DATA,
    output logic [N_IN-1:0]         IN_READY,
    output logic                    OUT_VALID,
    output logic [WIDTH-1:0]        OUT_DATA,
    output logic [SEL_W-1:0]        OUT_SEL,
    input  logic                    OUT_READY
);

    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  base;
    logic [SEL_W-1:0]  gnt_idx;
    logic [SEL_W-1:0]  ptr_next;
    logic [2*N_IN-1:0] rot;
    logic [N_IN-1:0]   gnt;
    logic [WIDTH-1:0]  gnt_data;
    logic              found;
    logic              load;
    logic              xfer;

    // Fixed priority is just round-robin with the search origin pinned to 0.
    assign base = (RR_MODE != 0) ? ptr : '0;

    // Rotating a doubled copy of IN_VALID puts channel (base+k) mod N_IN at bit k,
    // so the first set bit of the low half is the winner.
    always_comb begin
        int sum;
        sum     = 0;
        rot     = {IN_VALID, IN_VALID} >> base;
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N_IN; k++) begin
            sum = int'(base) + k;
            if (sum >= N_IN) begin
                sum = sum - N_IN;
            end
            if (!found && rot[k]) begin
                found   = 1'b1;
                gnt_idx = SEL_W'(sum);
            end
        end
    end

    always_comb begin
        gnt      = '0;
        gnt_data = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (found && (gnt_idx == SEL_W'(k))) begin
                gnt[k]   = 1'b1;
                gnt_data = IN_DATA[k*WIDTH +: WIDTH];
            end
        end
    end

    // Register can take a new word when empty or being drained this cycle.
    assign load     = !OUT_VALID || OUT_READY;
    assign xfer     = found && load;
    assign IN_READY = gnt & {N_IN{load && !RST}};
    assign ptr_next = (gnt_idx == SEL_W'(N_IN - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
            OUT_SEL   <= '0;
            ptr       <= '0;
        end else begin
            if (xfer) begin
                OUT_VALID <= 1'b1;
                OUT_DATA  <= gnt_data;
                OUT_SEL   <= gnt_idx;
                if (RR_MODE != 0) begin
                    ptr <= ptr_next;
                end
            end else if (OUT_READY) begin
                OUT_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rr_mux_reg.md
Name: rr_mux_reg

Overview:
- Parametrised N-input, WIDTH-bit arbitrating multiplexer with a registered output stage and valid/ready handshakes on every channel.
- Generalises the 32-bit 2:1 combinational mux to N channels. Adds two arbitration modes (fixed priority / round-robin) and back-pressure.
- Sits between multiple datapath producers (e.g. writeback sources, load/store return paths) and a single consumer port of the Proyecto_2 processor.

Parameters:
- WIDTH, 32, data width per channel.
- N_IN, 4, number of input channels (2..16).
- RR_MODE, 1, 1 = round-robin arbitration; 0 = fixed priority, lowest index wins.
- SEL_W, (N_IN>1 ? $clog2(N_IN) : 1), width of the channel index; derived, not to be overridden.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset.
- IN_VALID  input  N_IN  bit i = channel i presents data.
- IN_DATA  input  N_IN*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
- IN_READY  output  N_IN  bit i = channel i transfer accepted this cycle (combinational).
- OUT_VALID  output  1  output register holds valid data.
- OUT_DATA  output  WIDTH  registered selected data.
- OUT_SEL  output  SEL_W  index of the channel whose data is in OUT_DATA.
- OUT_READY  input  1  consumer accepts OUT_DATA this cycle.

Behaviour:
- Reset (RST=1 at a CLK edge): OUT_VALID=0, OUT_DATA=0, OUT_SEL=0, RR pointer PTR=0. IN_READY=0 while RST=1.
- Reset mid-transfer: data in the output register is discarded; there is no partial completion.
- Load enable: LOAD = !OUT_VALID || OUT_READY. This gives a full-throughput single-entry pipeline stage.
- Grant, combinational, one-hot or zero:
  - RR_MODE=0: lowest i with IN_VALID[i].
  - RR_MODE=1: first i with IN_VALID[i], searching PTR, PTR+1, ... N_IN-1, wrapping to 0 .. PTR-1.
- IN_READY[i] = GNT[i] && LOAD && !RST. At most one IN_READY bit is high per cycle.
- Transfer on channel i when IN_VALID[i] && IN_READY[i]. At the next edge:
  - OUT_DATA <= IN_DATA[i]
  - OUT_SEL <= i
  - OUT_VALID <= 1
- Output drain: if OUT_VALID && OUT_READY and no input transfer, OUT_VALID <= 0. OUT_DATA and OUT_SEL hold their last value.
- Simultaneous drain + load: the register is refilled in the same edge and OUT_VALID stays 1. Sustained throughput is 1 word/cycle.
- Stall: OUT_VALID && !OUT_READY holds OUT_DATA, OUT_SEL and OUT_VALID stable. All IN_READY=0.
- Latency: 1 cycle from input transfer to OUT_VALID.
- RR pointer update: only on a transfer, PTR <= (granted i + 1) mod N_IN. Wrap from N_IN-1 goes to 0. PTR does not change when nothing is granted.
- RR_MODE=0: PTR is unused and held at 0.
- Inputs: a producer must hold IN_VALID and IN_DATA stable until accepted. The block does not check this.
- OUT_DATA is 0 after reset until the first transfer. Consumers qualify OUT_DATA with OUT_VALID only.
- N_IN not a power of 2: index values >= N_IN are never produced.

Test Plan:
- Reset: assert RST for 2 cycles with all IN_VALID=1 -> IN_READY=0, OUT_VALID=0, OUT_DATA=0, OUT_SEL=0. First post-reset cycle grants ch0.
- Basic select, RR_MODE=1, N_IN=4, OUT_READY=1, only ch2 valid with 32'h55555555 -> IN_READY=4'b0100. Next cycle OUT_DATA=32'h55555555, OUT_SEL=2, OUT_VALID=1.
- Round-robin fairness: all 4 valid (ch0=32'hAAAAAAAA, ch1=32'h12345678, ch2=32'h87654321, ch3=32'hFFFFFFFF), OUT_READY=1 for 8 cycles -> OUT_SEL sequence 0,1,2,3,0,1,2,3. OUT_VALID=1 every cycle after the first.
- Fixed priority, RR_MODE=0: ch1 and ch3 continuously valid -> OUT_SEL=1 every cycle. IN_READY[3] never asserts.
- Back-pressure: OUT_READY=0 for 3 cycles with ch0 valid -> OUT_DATA held, IN_READY=0. Raising OUT_READY gives a drain and refill in the same edge with no bubble.
- Mid-stream reset: RST=1 while OUT_VALID=1 and OUT_READY=0 -> next edge OUT_VALID=0, PTR=0. Arbitration restarts from ch0.
